// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the system RAM between master 0 (CPU datapath) and
// master 1 (loader / DMA).
//
// IDLE -> ACCESS (RAM_WAIT+1 cycles of mem_cs) -> DONE (ack + rdata).
// DONE re-arbitrates, so back-to-back accesses take RAM_WAIT+2 cycles.
//
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin tie-break using a last_owner register
//   undefined : fixed priority, master 0 always wins a tie
module ram_arbiter #(
  parameter int WORD_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int RAM_WAIT = 0
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              r_nw0,
  input  logic              r_nw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_cs,
  output logic              mem_r_nw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RAM_WAIT);

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic       take;
  logic       win;

`ifdef ARB_RR_EN
  logic last_owner;

  // Winner select: a lone request wins, a tie goes to whoever was not served last.
  always_comb begin
    win = req1 & (~req0 | ~last_owner);
  end

  // Remember the last master granted so ties alternate.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)  last_owner <= 1'b1;
    else if (take) last_owner <= win;
  end
`else
  // Winner select: master 1 only when master 0 is not asking.
  always_comb begin
    win = req1 & ~req0;
  end
`endif

  // rdata is the RAM output itself; meaningful only while the owner's ack is high.
  assign rdata = mem_rdata;

  // Next state, arbitration trigger and state-decoded outputs.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    mem_cs   = 1'b0;
    busy     = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state)
      IDLE: begin
        take = req0 | req1;
        if (take) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_cs = 1'b1;
        busy   = 1'b1;
        if (cnt == 3'd0) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        ack0     = ~owner;
        ack1     = owner;
        take     = req0 | req1;
        state_nx = take ? ACCESS : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, grant pulses, request capture and wait counter.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      owner     <= 1'b0;
      mem_r_nw  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      gnt0  <= take & ~win;
      gnt1  <= take & win;
      if (take) begin
        // RAM-side signals only change here, so they stay put through IDLE.
        owner     <= win;
        mem_r_nw  <= win ? r_nw1  : r_nw0;
        mem_addr  <= win ? addr1  : addr0;
        mem_wdata <= win ? wdata1 : wdata0;
        cnt       <= WAIT_INIT;
      end else if (state == ACCESS && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter. A behavioural synchronous
// RAM sits on the mem_* side; expected acks are queued as requests are issued
// and popped by a monitor when an ack appears.
module tb_ram_arbiter;

  localparam int W  = 2;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          n_reset;
  logic          req0, req1, r_nw0, r_nw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata;
  logic          mem_cs, mem_r_nw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          owner, busy;

  typedef struct {
    bit            m;
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ram [32];
  logic [DW-1:0] sh  [32];
  int            n_chk  = 0;
  int            n_fail = 0;
  bit            last   = 1'b1;

  always #5 clock = ~clock;

  ram_arbiter #(.WORD_W(DW), .ADDR_W(AW), .RAM_WAIT(W)) dut (
    .clock(clock), .n_reset(n_reset),
    .req0(req0), .req1(req1), .r_nw0(r_nw0), .r_nw1(r_nw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_cs(mem_cs), .mem_r_nw(mem_r_nw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  // Synchronous RAM: write or read on every mem_cs cycle.
  always @(posedge clock) begin
    if (mem_cs && !mem_r_nw) ram[mem_addr] <= mem_wdata;
    if (mem_cs &&  mem_r_nw) mem_rdata     <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Ack monitor: every ack must match the oldest queued expectation.
  always @(negedge clock) begin
    if (n_reset && (ack0 || ack1)) begin
      chk("ack_both", {31'd0, ack0 & ack1}, 32'd0);
      if (sb.size() == 0) begin
        chk("ack_spurious", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_who", {31'd0, ack1}, {31'd0, e.m});
        if (e.rd) chk("rdata", {24'd0, rdata}, {24'd0, e.data});
      end
    end
  end

  // One isolated access from IDLE, checking every cycle of it.
  task automatic do_access(input bit m, input bit rnw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    exp_t e;
    if (m) begin req1 = 1; r_nw1 = rnw; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; r_nw0 = rnw; addr0 = a; wdata0 = d; end
    e.m = m; e.rd = rnw; e.data = sh[a];
    sb.push_back(e);
    if (!rnw) sh[a] = d;
    step();
    chk("gnt_mine",  {31'd0, m ? gnt1 : gnt0}, 32'd1);
    chk("gnt_other", {31'd0, m ? gnt0 : gnt1}, 32'd0);
    chk("owner",     {31'd0, owner}, {31'd0, m});
    last = m;
    // Inputs are don't-care after gnt: scramble them to prove they were captured.
    req0 = 0; req1 = 0;
    addr0 = ~a; addr1 = ~a; wdata0 = ~d; wdata1 = ~d; r_nw0 = ~rnw; r_nw1 = ~rnw;
    for (int i = 0; i <= W; i++) begin
      if (i > 0) begin
        step();
        chk("gnt_once", {31'd0, gnt0 | gnt1}, 32'd0);
      end
      chk("cs_held",  {31'd0, mem_cs}, 32'd1);
      chk("mem_addr", {27'd0, mem_addr}, {27'd0, a});
      chk("mem_rnw",  {31'd0, mem_r_nw}, {31'd0, rnw});
      if (!rnw) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
    end
    step();
    chk("done_cs",  {31'd0, mem_cs}, 32'd0);
    chk("done_ack", {31'd0, m ? ack1 : ack0}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd1);
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_addr_hold", {27'd0, mem_addr}, {27'd0, a});
  endtask

  // Both masters requesting reads continuously for n grants.
  task automatic tie_run(input int n);
    exp_t e;
    bit   expm;
    req0 = 1; req1 = 1; r_nw0 = 1; r_nw1 = 1; addr0 = 5'd3; addr1 = 5'd4;
    for (int g = 0; g < n; g++) begin
`ifdef ARB_RR_EN
      expm = ~last;
`else
      expm = 1'b0;
`endif
      step();
      chk("tie_gnt0", {31'd0, gnt0}, {31'd0, ~expm});
      chk("tie_gnt1", {31'd0, gnt1}, {31'd0, expm});
      e.m = expm; e.rd = 1; e.data = expm ? sh[4] : sh[3];
      sb.push_back(e);
      last = expm;
      if (g == n - 1) begin req0 = 0; req1 = 0; end
      for (int k = 0; k <= W; k++) begin
        step();
        chk("tie_nognt", {31'd0, gnt0 | gnt1}, 32'd0);
        chk("tie_busy",  {31'd0, busy}, 32'd1);
      end
    end
    step();
    chk("tie_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      ram[i] = 8'(i * 7 + 1);
      sh[i]  = 8'(i * 7 + 1);
    end
    ram[5'h0A] = 8'h3C; sh[5'h0A] = 8'h3C;
    n_reset = 0; req0 = 0; req1 = 0; r_nw0 = 0; r_nw1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt",   {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst_ack",   {30'd0, ack0, ack1}, 32'd0);
    chk("rst_cs",    {31'd0, mem_cs}, 32'd0);
    chk("rst_rnw",   {31'd0, mem_r_nw}, 32'd0);
    chk("rst_addr",  {27'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clock) n_reset = 1;
    step();

    // Single read, single write, read-back.
    do_access(0, 1, 5'h0A, 8'h00);
    do_access(1, 0, 5'h1F, 8'hA5);
    do_access(0, 1, 5'h1F, 8'h00);

    // Back-to-back: write then read from master 0 with req held through ack.
    req0 = 1; r_nw0 = 0; addr0 = 5'd7; wdata0 = 8'h11;
    e.m = 0; e.rd = 0; e.data = 0; sb.push_back(e);
    sh[7] = 8'h11;
    step();
    chk("b2b_gnt_a", {31'd0, gnt0}, 32'd1);
    last = 0;
    r_nw0 = 1; addr0 = 5'd7; wdata0 = 8'hEE;
    e.m = 0; e.rd = 1; e.data = 8'h11; sb.push_back(e);
    repeat (W + 1) step();
    chk("b2b_ack_a", {31'd0, ack0}, 32'd1);
    chk("b2b_busy_a", {31'd0, busy}, 32'd1);
    chk("b2b_nognt", {31'd0, gnt0}, 32'd0);
    step();
    chk("b2b_gnt_b", {31'd0, gnt0}, 32'd1);
    chk("b2b_busy_b", {31'd0, busy}, 32'd1);
    chk("b2b_cs_b",  {31'd0, mem_cs}, 32'd1);
    chk("b2b_rnw_b", {31'd0, mem_r_nw}, 32'd1);
    req0 = 0;
    repeat (W + 1) step();
    chk("b2b_ack_b", {31'd0, ack0}, 32'd1);
    step();
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Sustained tie.
    tie_run(4);

    // Reset during the second mem_cs cycle: access abandoned, no ack.
    req0 = 1; r_nw0 = 1; addr0 = 5'h0A;
    step();
    chk("mid_gnt", {31'd0, gnt0}, 32'd1);
    req0 = 0;
    step();
    chk("mid_cs2", {31'd0, mem_cs}, 32'd1);
    n_reset = 0;
    #1;
    chk("mid_rst_cs",   {31'd0, mem_cs}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ga",   {28'd0, gnt0, gnt1, ack0, ack1}, 32'd0);
    chk("mid_rst_addr", {27'd0, mem_addr}, 32'd0);
    last = 1;
    repeat (2) @(posedge clock);
    @(negedge clock) n_reset = 1;
    for (int i = 0; i < W + 3; i++) begin
      step();
      chk("post_rst_ack",  {30'd0, ack0, ack1}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    // After reset the first tie goes to master 0 in either mode.
    tie_run(1);
    do_access(1, 1, 5'h1F, 8'h00);

    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single system RAM between the CPU sequencer/datapath (master 0) and a second bus master (master 1: program loader / DMA). It accepts level requests, picks a winner, drives the RAM chip-select, direction, address and write-data for a programmable number of cycles, and returns a one-cycle acknowledge with read data. It sits between the CPU's MAR/MDR path and the RAM; the sequencer then stalls on `ack0` instead of relying on fixed cycle counts.

## Interface
Parameters:
- WORD_W, 8, RAM data width
- ADDR_W, 5, RAM address width (WORD_W - OP_W)
- RAM_WAIT, 0, extra cycles `mem_cs` is held per access (0..7)

Ports:
- clock  in  1  system clock, rising edge
- n_reset  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request, level
- r_nw0, r_nw1  in  1  1 = read, 0 = write
- addr0, addr1  in  ADDR_W  access address
- wdata0, wdata1  in  WORD_W  write data
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, inputs captured
- ack0, ack1  out  1  one-cycle pulse: access complete
- rdata  out  WORD_W  = mem_rdata; valid only while the owner's ack is high
- mem_cs  out  1  RAM chip select
- mem_r_nw  out  1  RAM direction
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  WORD_W  RAM write data (registered)
- mem_rdata  in  WORD_W  RAM read data, synchronous, valid the cycle after last `mem_cs` cycle
- owner  out  1  master currently or last served
- busy  out  1  high in ACCESS and DONE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req high, select winner, capture its addr/wdata/r_nw into mem_addr/mem_wdata/mem_r_nw, set owner, load wait counter with RAM_WAIT, go ACCESS. Else stay.
- ACCESS: mem_cs=1; gnt_owner=1 in first ACCESS cycle only. Counter decrements each cycle; at 0 go DONE.
- DONE: mem_cs=0, ack_owner=1, rdata valid for reads. Arbitrate again: if any req high, capture and go ACCESS directly; else IDLE.
- Arbitration (ARB_RR_EN defined): single request wins; both high -> master != last owner. last_owner resets to 1, so master 0 wins first tie.
- Master protocol: keep req and inputs stable until gnt; inputs are don't-care after gnt. A req still high in the ack cycle is a new request.
- Master never receives gnt while its previous access is outstanding.
- mem_addr/mem_wdata/mem_r_nw hold their values in IDLE (no glitching); only mem_cs qualifies the access.
- Reset mid-access: async return to IDLE, all outputs to reset values immediately, access abandoned, no ack issued.

## Timing
- Reset values: gnt0=gnt1=ack0=ack1=0, mem_cs=0, mem_r_nw=0, mem_addr=0, mem_wdata=0, owner=0, busy=0, last_owner=1.
- Latency, RAM_WAIT=W: req sampled at edge N (IDLE) -> gnt and mem_cs in cycle N+1 -> mem_cs held cycles N+1..N+1+W -> ack in cycle N+2+W.
- Throughput: back-to-back accesses every W+2 cycles (DONE overlaps next arbitration).
- All outputs registered or decoded from registered state; no combinational path from req to gnt/mem_*.
- rdata is a pass-through, not registered; consumer samples on the edge ending the ack cycle.

## Configuration
- ARB_RR_EN defined: round-robin tie-break as above; owner alternates under sustained dual requests.
- ARB_RR_EN undefined: fixed priority, master 0 always wins ties; last_owner register removed; master 1 served only when req0 low at arbitration.

## Test plan
- Single read, W=0: req0=1, r_nw0=1, addr0=5'h0A, RAM holds 8'h3C -> gnt0 cycle 1, mem_cs cycle 1 only, ack0 cycle 2 with rdata=8'h3C.
- Single write, W=2: req1=1, r_nw1=0, addr1=5'h1F, wdata1=8'hA5 -> mem_cs cycles 1-3 with mem_addr=1F, mem_wdata=A5, mem_r_nw=0; ack1 cycle 4; read-back returns A5.
- Tie, ARB_RR_EN: req0=req1=1 held -> grants 0,1,0,1 every 2 cycles; without macro -> gnt0 every 2 cycles, gnt1 never.
- Back-to-back: req0 held through ack -> second gnt0 in the cycle after ack, busy stays 1, no IDLE cycle.
- Reset mid-access, W=3: assert n_reset low during second mem_cs cycle -> mem_cs, busy, gnt, ack fall immediately; no ack after release; next req served normally.
- Input hold: change addr0 after gnt0 -> mem_addr unchanged for remainder of access.
